// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life board controller: key event codes,
// controller state encoding and the engine hand-off timeout.
package life_pkg;

  // One-cycle key events presented on the keys input
  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_UP    = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_LEFT  = 3'd3,
    KEY_RIGHT = 3'd4,
    KEY_FLIP  = 3'd5,
    KEY_NEXT  = 3'd6,
    KEY_RUN   = 3'd7
  } key_e;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLIP_RD  = 3'd1,
    S_FLIP_WR  = 3'd2,
    S_GEN_WAIT = 3'd3,
    S_GEN      = 3'd4
  } state_e;

  // Cycles GEN_WAIT waits for the engine to raise busy before giving up
  localparam int WAIT_TIMEOUT = 4;
  localparam int WAIT_W       = 3;

endpackage

// File: rtl/life_ctrl_if.sv
// Cell-memory port and generation-engine handshake shared by the controller
// (master) and the memory/engine side (slave).
interface life_ctrl_if #(
  parameter int X     = 16,
  parameter int LOG2Y = 4
);
  logic             eng_start;
  logic             eng_busy;
  logic [LOG2Y-1:0] mem_addr;
  logic             mem_we;
  logic [X-1:0]     mem_wdata;
  logic [X-1:0]     mem_rdata;

  modport master (
    output eng_start,
    input  eng_busy,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  eng_start,
    output eng_busy,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/life_scan.sv
// Display scanner: walks rows 0..Y-1, holding each for ROW_HOLD cycles. At the
// start of a slot it requests a read of the row; while the request is denied the
// slot timer is frozen and the previous row/col stay on the display.
module life_scan #(
  parameter int X        = 16,
  parameter int Y        = 16,
  parameter int LOG2Y    = 4,
  parameter int ROW_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             o_req,
  input  logic             i_grant,
  output logic [LOG2Y-1:0] o_addr,
  input  logic [X-1:0]     i_rdata,
  output logic [Y-1:0]     o_row,
  output logic [X-1:0]     o_col
);
  localparam int HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam logic [HW-1:0]    HMAX = HW'(ROW_HOLD - 1);
  localparam logic [LOG2Y-1:0] YMAX = LOG2Y'(Y - 1);

  logic [LOG2Y-1:0] r_idx;
  logic [HW-1:0]    r_hold;
  logic             r_req;
  logic             r_load;
  logic [LOG2Y-1:0] r_load_idx;
  logic [Y-1:0]     r_row;
  logic [X-1:0]     r_col;
  logic             w_stall;

  assign w_stall = r_req && !i_grant;
  assign o_req   = r_req;
  assign o_addr  = r_idx;
  assign o_row   = r_row;
  assign o_col   = r_col;

  // Slot sequencing: advance the hold counter unless a read request is waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_hold <= '0;
      r_req  <= 1'b1;
    end else if (!w_stall) begin
      if (r_req) r_req <= 1'b0;
      if (r_hold == HMAX) begin
        r_hold <= '0;
        r_idx  <= (r_idx == YMAX) ? '0 : r_idx + LOG2Y'(1);
        r_req  <= 1'b1;
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  // Read data arrives the cycle after the grant; latch it with the row it belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load     <= 1'b0;
      r_load_idx <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_load <= r_req && i_grant;
      if (r_req && i_grant) r_load_idx <= r_idx;
      if (r_load) begin
        r_row <= Y'(1) << r_load_idx;
        r_col <= i_rdata;
      end
    end
  end
endmodule

// File: rtl/life_ctrl.sv
// Game-of-Life board controller: cursor editing with read-modify-write cell
// flips, single-step and free-running generation requests to the engine, and
// arbitration of the single cell-memory port between engine, flip and display.
module life_ctrl
  import life_pkg::*;
#(
  parameter int X          = 16,
  parameter int Y          = 16,
  parameter int LOG2X      = 4,
  parameter int LOG2Y      = 4,
  parameter int ROW_HOLD   = 16,
  parameter int GEN_PERIOD = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        keys,
  life_ctrl_if.master       bus,
  output logic [Y-1:0]      row,
  output logic [X-1:0]      col,
  output logic [LOG2X-1:0]  cur_x,
  output logic [LOG2Y-1:0]  cur_y,
  output logic              running
);
  localparam int TW = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;
  localparam logic [TW-1:0]    TMAX = TW'(GEN_PERIOD - 1);
  localparam logic [LOG2X-1:0] XMAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YMAX = LOG2Y'(Y - 1);

  state_e            r_state;
  state_e            w_next;
  logic [LOG2X-1:0]  r_cur_x;
  logic [LOG2Y-1:0]  r_cur_y;
  logic              r_running;
  logic              r_pending;
  logic              r_eng_start;
  logic [TW-1:0]     r_timer;
  logic [WAIT_W-1:0] r_wait;

  logic              w_idle;
  logic              w_run_key;
  logic              w_key_ok;
  logic              w_flip_go;
  logic              w_gen_go;
  logic              w_expire;
  logic              w_scan_req;
  logic              w_scan_grant;
  logic [LOG2Y-1:0]  w_scan_addr;

  assign w_idle    = (r_state == S_IDLE);
  assign w_run_key = (keys == KEY_RUN);
  // Edit keys only count in IDLE while stopped and with no queued generation
  assign w_key_ok  = w_idle && !r_running && !r_pending;
  assign w_flip_go = w_key_ok && (keys == KEY_FLIP);
  assign w_gen_go  = w_idle && (r_pending || (!r_running && keys == KEY_NEXT));
  assign w_expire  = r_running && !w_run_key && (r_timer == TMAX);
  // Engine and flip own the port outside IDLE; a flip starting now also beats the scan
  assign w_scan_grant = w_scan_req && w_idle && !w_flip_go;

  assign bus.eng_start = r_eng_start;
  assign cur_x         = r_cur_x;
  assign cur_y         = r_cur_y;
  assign running       = r_running;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gen_go)       w_next = S_GEN_WAIT;
        else if (w_flip_go) w_next = S_FLIP_RD;
      end
      S_FLIP_RD: w_next = S_FLIP_WR;
      S_FLIP_WR: w_next = S_IDLE;
      S_GEN_WAIT: begin
        if (bus.eng_busy)                              w_next = S_GEN;
        else if (r_wait == WAIT_W'(WAIT_TIMEOUT - 1))  w_next = S_IDLE;
      end
      S_GEN: if (!bus.eng_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory port mux: engine states leave the port idle at address 0
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (r_state)
      S_FLIP_RD: bus.mem_addr = r_cur_y;
      S_FLIP_WR: begin
        bus.mem_addr  = r_cur_y;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.mem_rdata ^ (X'(1) << r_cur_x);
      end
      S_IDLE: if (w_scan_grant) bus.mem_addr = w_scan_addr;
      default: ;
    endcase
  end

  // Engine start pulse and GEN_WAIT timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_eng_start <= 1'b0;
      r_wait      <= '0;
    end else begin
      r_eng_start <= w_gen_go;
      r_wait      <= (r_state == S_GEN_WAIT) ? r_wait + WAIT_W'(1) : '0;
    end
  end

  // Cursor movement with wrap-around in both directions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else if (w_key_ok) begin
      case (keys)
        KEY_UP:    r_cur_y <= (r_cur_y == '0)   ? YMAX : r_cur_y - LOG2Y'(1);
        KEY_DOWN:  r_cur_y <= (r_cur_y == YMAX) ? '0   : r_cur_y + LOG2Y'(1);
        KEY_LEFT:  r_cur_x <= (r_cur_x == '0)   ? XMAX : r_cur_x - LOG2X'(1);
        KEY_RIGHT: r_cur_x <= (r_cur_x == XMAX) ? '0   : r_cur_x + LOG2X'(1);
        default: ;
      endcase
    end
  end

  // Run flag, generation timer and pending generation (extra expiries collapse into one)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_running <= 1'b0;
      r_timer   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_run_key) r_running <= !r_running;
      if (!r_running || w_run_key) r_timer <= '0;
      else if (r_timer == TMAX)    r_timer <= '0;
      else                         r_timer <= r_timer + TW'(1);
      r_pending <= (r_pending && !w_idle) || w_expire;
    end
  end

  life_scan #(
    .X        (X),
    .Y        (Y),
    .LOG2Y    (LOG2Y),
    .ROW_HOLD (ROW_HOLD)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .o_req   (w_scan_req),
    .i_grant (w_scan_grant),
    .o_addr  (w_scan_addr),
    .i_rdata (bus.mem_rdata),
    .o_row   (row),
    .o_col   (col)
  );
endmodule

// File: doc/life_ctrl.md
LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 The block SHALL have parameter X, default 16, meaning board columns.
REQ-002 The block SHALL have parameter Y, default 16, meaning board rows.
REQ-003 The block SHALL have parameters LOG2X, default 4, and LOG2Y, default 4, meaning column and row index widths.
REQ-004 The block SHALL have parameter ROW_HOLD, default 16, meaning cycles each display row is driven.
REQ-005 The block SHALL have parameter GEN_PERIOD, default 256, meaning cycles between automatic generations.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 keys  input  3  one-cycle key event: 0 none, 1 up, 2 down, 3 left, 4 right, 5 flip, 6 next, 7 run/stop.
REQ-009 eng_start  output  1  one-cycle pulse starting one generation in the engine.
REQ-010 eng_busy  input  1  engine owns cell memory while high.
REQ-011 mem_addr  output  LOG2Y  cell-memory row address.
REQ-012 mem_we  output  1  row write enable.
REQ-013 mem_wdata  output  X  row write data.
REQ-014 mem_rdata  input  X  row read data, valid one cycle after address.
REQ-015 row  output  Y  one-hot row drive; col  output  X  column data of driven row.
REQ-016 cur_x  output  LOG2X and cur_y  output  LOG2Y: edit cursor; running  output  1: auto-run flag.

Function
REQ-017 The controller SHALL have states IDLE, FLIP_RD, FLIP_WR, GEN_WAIT, GEN.
REQ-018 In IDLE, up/down SHALL decrement/increment cur_y modulo Y; left/right SHALL decrement/increment cur_x modulo X (0-1 wraps to max).
REQ-019 Flip in IDLE SHALL go to FLIP_RD (read row cur_y), then FLIP_WR (write mem_rdata XOR bit cur_x, mem_we=1 one cycle), then IDLE.
REQ-020 Next in IDLE with running=0 SHALL pulse eng_start and enter GEN_WAIT; GEN_WAIT goes to GEN when eng_busy=1; GEN goes to IDLE when eng_busy=0.
REQ-021 GEN_WAIT SHALL time out to IDLE after 4 cycles without eng_busy.
REQ-022 Run/stop SHALL toggle running in any state; clearing running SHALL zero the generation timer.
REQ-023 With running=1, the timer SHALL count every cycle; at GEN_PERIOD-1 it sets a pending flag and wraps to 0.
REQ-024 Pending SHALL be serviced on IDLE as a next-generation start (REQ-020) and cleared; further expiries while pending are absorbed.
REQ-025 With running=1, next, flip and cursor keys SHALL be ignored.
REQ-026 Keys arriving outside IDLE (except run/stop) SHALL be dropped, not queued.
REQ-027 Display scan SHALL cycle rows 0..Y-1 wrapping, each ROW_HOLD cycles; at slot start it requests a read of that row.
REQ-028 Memory port priority SHALL be: engine (GEN_WAIT/GEN, mem_we=0, mem_addr=0) > flip RMW > scan read.
REQ-029 A denied scan read SHALL retry each cycle, row/col holding previous values, row slot timer paused.
REQ-030 On granted scan read, row SHALL become one-hot of the row and col SHALL become mem_rdata in the following cycle.
REQ-031 Flip requested in the same cycle as a scan read SHALL win; scan retries next cycle.

Reset
REQ-032 On reset: state IDLE, eng_start=0, mem_we=0, mem_addr=0, mem_wdata=0, row=0, col=0, cur_x=0, cur_y=0, running=0, timer=0, pending=0, scan row 0.
REQ-033 Reset mid-GEN or mid-flip SHALL abandon the operation with no write issued after reset assertion.

Structure
REQ-034 Key codes and the state encoding SHALL live in shared package life_pkg.
REQ-035 The display scanner SHALL be sub-module life_scan with request/grant to the controller.

Verification
REQ-036 Keys right x3, down x2, flip, rdata row2=0x0000 -> write addr 2 data 0x0008, cur=(3,2).
REQ-037 Left at cur_x=0 and up at cur_y=0 -> cur_x=15, cur_y=15.
REQ-038 Next, eng_busy high cycles 2-9 -> one eng_start pulse, no mem_we, IDLE at cycle 11, scan paused then resumes.
REQ-039 Run/stop, GEN_PERIOD=256, engine busy 300 cycles -> second start only after busy falls; exactly one pending serviced.
REQ-040 Flip and scan request same cycle -> flip write first, scan row read next cycle, col matches rdata.
REQ-041 Reset asserted in FLIP_RD -> no mem_we, all outputs at reset values asynchronously.
